fifo_v4: RTL and testbench

//  Parametrised synchronous FIFO; successor to the fixed-threshold FIFO wrapper.

---
 rtl/fifo_v4_if.sv | 35 +++
 rtl/fifo_v4.sv | 99 +++++++++
 tb/tb_fifo_v4.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_v4_if.sv
// Handshake bundle for fifo_v4: push side, pop side, clear/flush, thresholds and status.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_v4_if #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 8,
  parameter type dtype      = logic [DATA_WIDTH-1:0]
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clr_i;
  logic             flush_i;
  logic             full_o;
  logic             empty_o;
  logic [CNT_W-1:0] usage_o;
  logic [CNT_W-1:0] alm_full_th_i;
  logic [CNT_W-1:0] alm_empty_th_i;
  logic             alm_full_o;
  logic             alm_empty_o;
  dtype             data_i;
  logic             push_i;
  dtype             data_o;
  logic             pop_i;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output clr_i, flush_i, alm_full_th_i, alm_empty_th_i, data_i, push_i, pop_i,
    input  full_o, empty_o, usage_o, alm_full_o, alm_empty_o, data_o, overflow_o, underflow_o
  );

  modport slave (
    input  clr_i, flush_i, alm_full_th_i, alm_empty_th_i, data_i, push_i, pop_i,
    output full_o, empty_o, usage_o, alm_full_o, alm_empty_o, data_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_v4.sv
// Synchronous FIFO, arbitrary depth, runtime almost-full/empty thresholds, optional fall-through.
// Define FIFO_V4_ERR_EN to build the sticky overflow/underflow flags.
module fifo_v4 #(
  parameter bit  FALL_THROUGH = 1'b0,
  parameter int  DATA_WIDTH   = 32,
  parameter int  DEPTH        = 8,
  parameter type dtype        = logic [DATA_WIDTH-1:0],
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input logic      clk_i,
  input logic      rst_i,
  fifo_v4_if.slave bus
);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  dtype             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             clear;
  logic             is_empty;
  logic             is_full;
  logic             bypass;
  logic             empty_now;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    clear     = bus.clr_i | bus.flush_i;
    is_empty  = (cnt == '0);
    is_full   = (cnt == FULL_CNT);
    bypass    = FALL_THROUGH && is_empty && bus.push_i;
    empty_now = is_empty && !bypass;
    pop_ok    = bus.pop_i && !is_empty;
    // a bypassed element that is popped in the same cycle never touches storage
    push_ok   = bus.push_i && !is_full && !(bypass && bus.pop_i);
  end

  assign bus.full_o      = is_full;
  assign bus.empty_o     = empty_now;
  assign bus.usage_o     = cnt;
  assign bus.alm_full_o  = (cnt >= bus.alm_full_th_i);
  assign bus.alm_empty_o = (cnt <= bus.alm_empty_th_i);
  assign bus.data_o      = bypass ? bus.data_i : mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.data_i;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO_V4_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push_i && is_full)   overflow_q  <= 1'b1;
      if (bus.pop_i && empty_now)  underflow_q <= 1'b1;
    end
  end

  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;
`else
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_v4.sv
// Directed bench for fifo_v4: DEPTH=5 registered-head instance driven against a queue
// scoreboard, plus a DEPTH=5 fall-through instance for the bypass cases.
module tb_fifo_v4;
  localparam int D = 5;
`ifdef FIFO_V4_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] sb_q[$];
  int   th_f = 3;
  int   th_e = 1;

  fifo_v4_if #(.DATA_WIDTH(8), .DEPTH(D)) a_if ();
  fifo_v4_if #(.DATA_WIDTH(8), .DEPTH(D)) b_if ();

  fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(D)) dut_a (.clk_i(clk), .rst_i(rst), .bus(a_if));
  fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(D)) dut_b (.clk_i(clk), .rst_i(rst), .bus(b_if));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = sb_q.size();
    check({tag, ".usage"},  32'(a_if.usage_o),     32'(n));
    check({tag, ".empty"},  32'(a_if.empty_o),     32'(n == 0));
    check({tag, ".full"},   32'(a_if.full_o),      32'(n == D));
    check({tag, ".afull"},  32'(a_if.alm_full_o),  32'(n >= th_f));
    check({tag, ".aempty"}, 32'(a_if.alm_empty_o), 32'(n <= th_e));
  endtask

  // one clock on dut_a; status and head checked just before the edge
  task automatic cyc(input bit push, input bit pop, input logic [7:0] din, input string tag);
    bit acc_push, acc_pop;
    a_if.push_i = push;
    a_if.pop_i  = pop;
    a_if.data_i = din;
    #1;
    check_status(tag);
    acc_push = push && (sb_q.size() < D);
    acc_pop  = pop && (sb_q.size() > 0);
    if (acc_pop) check({tag, ".data"}, 32'(a_if.data_o), 32'(sb_q[0]));
    @(posedge clk);
    #1;
    if (acc_pop) void'(sb_q.pop_front());
    if (acc_push) sb_q.push_back(din);
    a_if.push_i = 1'b0;
    a_if.pop_i  = 1'b0;
  endtask

  task automatic clear_cycle(input bit use_flush, input bit with_push);
    if (use_flush) a_if.flush_i = 1'b1; else a_if.clr_i = 1'b1;
    a_if.push_i = with_push;
    a_if.pop_i  = 1'b0;
    a_if.data_i = 8'h99;
    @(posedge clk);
    #1;
    a_if.flush_i = 1'b0;
    a_if.clr_i   = 1'b0;
    a_if.push_i  = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    bit       exp_ae [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit       exp_af [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] v;

    a_if.clr_i = 0; a_if.flush_i = 0; a_if.push_i = 0; a_if.pop_i = 0; a_if.data_i = '0;
    a_if.alm_full_th_i = 3'(th_f); a_if.alm_empty_th_i = 3'(th_e);
    b_if.clr_i = 0; b_if.flush_i = 0; b_if.push_i = 0; b_if.pop_i = 0; b_if.data_i = '0;
    b_if.alm_full_th_i = 3'd3; b_if.alm_empty_th_i = 3'd1;

    // reset state, including alm_full following a zero threshold
    #2;
    check_status("rst");
    check("rst.ovf", 32'(a_if.overflow_o),  32'(0));
    check("rst.unf", 32'(a_if.underflow_o), 32'(0));
    a_if.alm_full_th_i = 3'd0;
    #1;
    check("rst.afull_th0", 32'(a_if.alm_full_o), 32'(1));
    a_if.alm_full_th_i = 3'(th_f);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fill to full with threshold table, overflow push, drain in order
    for (int i = 0; i < D; i++) begin
      if (i < 5) begin
        check($sformatf("thr.ae%0d", i), 32'(a_if.alm_empty_o), 32'(exp_ae[i]));
        check($sformatf("thr.af%0d", i), 32'(a_if.alm_full_o),  32'(exp_af[i]));
      end
      cyc(1, 0, 8'(8'h10 + i), "fill");
    end
    check("full.flag",  32'(a_if.full_o),  32'(1));
    check("full.usage", 32'(a_if.usage_o), 32'(D));
    cyc(1, 0, 8'hEE, "push_full");
    for (int i = 0; i < D; i++) cyc(0, 1, 8'h00, "drain");
    check("drain.empty", 32'(a_if.empty_o), 32'(1));

    // wrap: 3 deep, 12 concurrent push/pop cycles, then push+pop at full (push refused)
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h40 + i), "wrap_pre");
    for (int i = 0; i < 12; i++) cyc(1, 1, 8'(8'h50 + 7 * i), "wrap");
    check("wrap.usage", 32'(a_if.usage_o), 32'(3));
    cyc(1, 0, 8'hC1, "wrap_fill");
    cyc(1, 0, 8'hC2, "wrap_fill");
    cyc(1, 1, 8'hC3, "full_pushpop");
    while (sb_q.size() > 0) cyc(0, 1, 8'h00, "wrap_drain");
    check_status("wrap_end");

    // threshold change takes effect combinationally
    cyc(1, 0, 8'h21, "th_fill");
    cyc(1, 0, 8'h22, "th_fill");
    check("th.af_before", 32'(a_if.alm_full_o), 32'(0));
    th_f = 2;
    a_if.alm_full_th_i = 3'd2;
    #1;
    check("th.af_after", 32'(a_if.alm_full_o), 32'(1));
    th_e = 7;
    a_if.alm_empty_th_i = 3'd7;
    #1;
    check("th.ae_big", 32'(a_if.alm_empty_o), 32'(1));
    th_f = 6;
    a_if.alm_full_th_i = 3'd6;
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h23 + i), "th_big");
    check("th.af_never", 32'(a_if.alm_full_o), 32'(0));
    th_f = 3; th_e = 1;
    a_if.alm_full_th_i = 3'd3; a_if.alm_empty_th_i = 3'd1;

    // flush with push: usage goes to 0
    clear_cycle(1'b1, 1'b1);
    check("flush.usage", 32'(a_if.usage_o), 32'(0));
    check("flush.empty", 32'(a_if.empty_o), 32'(1));
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h60 + i), "pre_rst");
    check("pre_rst.usage", 32'(a_if.usage_o), 32'(3));

    // async reset mid-stream
    rst = 1'b1;
    #1;
    sb_q.delete();
    check_status("arst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 0, 8'h77, "post_rst");
    cyc(0, 1, 8'h00, "post_rst");
    check_status("post_rst_end");

    // fall-through instance
    b_if.push_i = 1'b1; b_if.pop_i = 1'b1; b_if.data_i = 8'hA5;
    #1;
    check("ft.data",  32'(b_if.data_o),  32'h A5);
    check("ft.empty", 32'(b_if.empty_o), 32'(0));
    check("ft.usage", 32'(b_if.usage_o), 32'(0));
    @(posedge clk);
    #1;
    b_if.pop_i = 1'b0; b_if.data_i = 8'h3C;
    #1;
    check("ft.bypass_usage", 32'(b_if.usage_o), 32'(0));
    check("ft.push_data",    32'(b_if.data_o),  32'h3C);
    @(posedge clk);
    #1;
    b_if.push_i = 1'b0; b_if.data_i = 8'h00;
    #1;
    check("ft.stored_usage", 32'(b_if.usage_o), 32'(1));
    check("ft.stored_data",  32'(b_if.data_o),  32'h3C);
    b_if.pop_i = 1'b1;
    @(posedge clk);
    #1;
    b_if.pop_i = 1'b0;
    #1;
    check("ft.empty_end", 32'(b_if.empty_o),     32'(1));
    check("ft.no_unf",    32'(b_if.underflow_o), 32'(0));

    // sticky error flags
    clear_cycle(1'b0, 1'b0);
    check("err.clr_ovf", 32'(a_if.overflow_o),  32'(0));
    for (int i = 0; i < D; i++) cyc(1, 0, 8'(8'h80 + i), "err_fill");
    cyc(1, 0, 8'hFF, "err_ovf");
    check("err.ovf_set", 32'(a_if.overflow_o), 32'(ERR_EN));
    cyc(0, 0, 8'h00, "err_hold");
    check("err.ovf_hold", 32'(a_if.overflow_o),  32'(ERR_EN));
    check("err.unf_clr",  32'(a_if.underflow_o), 32'(0));
    for (int i = 0; i < D; i++) cyc(0, 1, 8'h00, "err_drain");
    cyc(0, 1, 8'h00, "err_unf");
    check("err.unf_set", 32'(a_if.underflow_o), 32'(ERR_EN));
    clear_cycle(1'b0, 1'b0);
    check("err.clr_ovf2", 32'(a_if.overflow_o),  32'(0));
    check("err.clr_unf2", 32'(a_if.underflow_o), 32'(0));

    v = 8'h00;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
